// File: rtl/tl_ram_responder.sv
// TileLink-UL responder in front of a single-ported 64-bit word RAM.
// Serves Get / PutFullData / PutPartialData on A and answers on D.
// A single response register holds the outcome of the last accepted
// request. A new request is accepted whenever that register is empty or is
// being retired in the same cycle, so one transaction per cycle is possible.
//
// state | meaning
// ------+------------------------------------------------------------
// EMPTY | no response pending, d_valid low, A accepts unconditionally
// FULL  | response held on D until d_ready, A accepts only on retire
module tl_ram_responder #(
  parameter int          DEPTH = 512,
  parameter logic [63:0] BASE  = 64'h8000_0000,
  parameter int          SRC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid_i,
  input  logic [2:0]       a_opcode_i,
  input  logic [2:0]       a_param_i,
  input  logic [2:0]       a_size_i,
  input  logic [SRC_W-1:0] a_source_i,
  input  logic [63:0]      a_address_i,
  input  logic [7:0]       a_mask_i,
  input  logic [63:0]      a_data_i,
  output logic             a_ready_o,
  output logic             d_valid_o,
  output logic [2:0]       d_opcode_o,
  output logic [1:0]       d_param_o,
  output logic [2:0]       d_size_o,
  output logic [SRC_W-1:0] d_source_o,
  output logic             d_denied_o,
  output logic [63:0]      d_data_o,
  input  logic             d_ready_i
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [63:0] LIMIT = 64'(DEPTH) << 3;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [2:0]         opcode_q, opcode_d;
  logic [2:0]         size_q, size_d;
  logic [SRC_W-1:0]   source_q, source_d;
  logic               denied_q, denied_d;
  logic [63:0]        data_q, data_d;

  logic [63:0]        mem_q [DEPTH];

  logic [63:0]        offset;
  logic [IDX_W-1:0]   idx;
  logic               in_range, aligned, op_ok, is_get, is_put, err;
  logic               accept, wr_en;

  // Request decode: word index, range, alignment and opcode legality.
  always_comb begin
    offset   = a_address_i - BASE;
    idx      = offset[IDX_W+2:3];
    in_range = (a_address_i >= BASE) && (offset < LIMIT);
    aligned  = 1'b0;
    case (a_size_i)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = (a_address_i[0] == 1'b0);
      3'd2:    aligned = (a_address_i[1:0] == 2'b00);
      3'd3:    aligned = (a_address_i[2:0] == 3'b000);
      default: aligned = 1'b0;
    endcase
    is_get = (a_opcode_i == OP_GET);
    is_put = (a_opcode_i == OP_PUT_FULL) || (a_opcode_i == OP_PUT_PART);
    op_ok  = is_get || is_put;
    err    = ~op_ok | ~in_range | ~aligned;
  end

  assign a_ready_o = (state_q == EMPTY) | d_ready_i;
  assign accept    = a_valid_i & a_ready_o;
  // A Put handshaking while reset is asserted must not reach the RAM.
  assign wr_en     = accept & is_put & ~err & ~rst;

  // Next response: load on accept, otherwise drain when the master takes it.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    size_d   = size_q;
    source_d = source_q;
    denied_d = denied_q;
    data_d   = data_q;
    if (accept) begin
      state_d  = FULL;
      opcode_d = is_get ? OP_ACK_DATA : OP_ACK;
      size_d   = a_size_i;
      source_d = a_source_i;
      denied_d = err;
      data_d   = (is_get && !err) ? mem_q[idx] : 64'd0;
    end else if (d_ready_i) begin
      state_d = EMPTY;
    end
  end

  // Response register; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      opcode_q <= 3'd0;
      size_q   <= 3'd0;
      source_q <= '0;
      denied_q <= 1'b0;
      data_q   <= 64'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      size_q   <= size_d;
      source_q <= source_d;
      denied_q <= denied_d;
      data_q   <= data_d;
    end
  end

  // RAM byte-lane write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (a_mask_i[b]) mem_q[idx][8*b +: 8] <= a_data_i[8*b +: 8];
      end
    end
  end

  assign d_valid_o  = (state_q == FULL);
  assign d_opcode_o = opcode_q;
  assign d_param_o  = 2'd0;
  assign d_size_o   = size_q;
  assign d_source_o = source_q;
  assign d_denied_o = denied_q;
  assign d_data_o   = data_q;

  // a_param carries nothing for UL accesses; offset only feeds the index.
  logic unused_bits;
  assign unused_bits = ^{a_param_i, offset[63:IDX_W+3], offset[2:0]};

endmodule
